// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared FSM encoding, default widths and byte/word PC conversion
// for the instruction fetch stage.
package rv_fetch_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int PC_SHIFT = 2;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: control, instruction-memory, redirect and output handshake
// signals of the fetch stage; master = fetch side, slave = its environment.
interface instr_fetch_if
  import rv_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              start;
  logic              halt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [31:0]       out_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              busy;
  logic              done;
  logic              fault;
  modport master (
    input  start, halt, mem_q, out_ready, redirect_valid, redirect_pc,
    output mem_addr, out_valid, out_instr, out_pc, busy, done, fault
  );
  modport slave (
    output start, halt, mem_q, out_ready, redirect_valid, redirect_pc,
    input  mem_addr, out_valid, out_instr, out_pc, busy, done, fault
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry FIFO of {instr, pc} words with push/pop/clear; clear wins.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clr_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         rd_q, wr_q;
  logic [1:0]   count_q;
  logic         do_push, do_pop;
  assign do_pop  = pop_i && count_q != 2'd0;
  assign do_push = push_i && (count_q != 2'd2 || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q   <= '{default: '0};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
    end else if (clr_i) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_q] <= din_i;
      wr_q    <= wr_q ^ do_push;
      rd_q    <= rd_q ^ do_pop;
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, reads instruction memory and hands {instr, pc} pairs out.
// Define INSTR_FETCH_MISALIGN_EN to trap misaligned redirects into a sticky fault.
module instr_fetch
  import rv_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RESET_PC = 0
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, infl_pc_q;
  logic               infl_q, infl_ep_q, ep_q, done_q, done_d;
  logic               run, flush, issue, push, pop, bad, fault;
  logic [1:0]         count;
  logic [31:0]        infl_byte;
  logic [DATA_W+31:0] head;

`ifdef INSTR_FETCH_MISALIGN_EN
  logic fault_q;
  assign bad   = bus.redirect_valid && bus.redirect_pc[PC_SHIFT-1:0] != '0;
  assign fault = fault_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else if (bad) fault_q <= 1'b1;
  end
`else
  assign bad   = 1'b0;
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb
    state_d = (state_q == RUN) ? ((bus.halt || bad) ? IDLE : RUN)
                               : ((bus.start && !fault && !bad) ? RUN : IDLE);

  // Credit check keeps FIFO occupancy plus the in-flight read within 2 entries.
  always_comb begin
    run    = state_q == RUN;
    pop    = bus.out_valid && bus.out_ready;
    flush  = bus.redirect_valid || (run && bus.halt);
    issue  = run && !flush && (({1'b0, count} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));
    push   = infl_q && (infl_ep_q == ep_q) && !flush;
    done_d = run && bus.halt && !bad;
  end

  always_comb
    pc_d = (bus.redirect_valid && !bad) ? bus.redirect_pc[ADDR_W+PC_SHIFT-1:PC_SHIFT]
         : issue ? pc_q + ADDR_W'(1) : pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= ADDR_W'(RESET_PC);
      infl_q    <= 1'b0;
      infl_ep_q <= 1'b0;
      infl_pc_q <= '0;
      ep_q      <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= issue;
      infl_ep_q <= ep_q;
      infl_pc_q <= issue ? pc_q : infl_pc_q;
      ep_q      <= ep_q ^ flush;
    end
  end

  assign infl_byte = 32'(infl_pc_q) << PC_SHIFT;

  fetch_fifo #(.W(DATA_W + 32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (flush),
    .din_i   ({bus.mem_q, infl_byte}),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = count != 2'd0;
  assign bus.out_instr = head[DATA_W+31:32];
  assign bus.out_pc    = head[31:0];
  assign bus.busy      = run;
  assign bus.done      = done_q;
  assign bus.fault     = fault;
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the RISC-V core. Owns the program counter, drives the on-chip instruction memory (`instructions_mem`, 1-cycle synchronous read), and hands `{instruction, PC}` pairs to the control/execute FSM over a valid/ready handshake. Accepts PC redirects from the control stage for branches and jumps, discarding any wrong-path words.

## Interface
- `ADDR_W`, 8: instruction memory word-address width.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 0: word address loaded into the PC at reset.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled in IDLE to begin fetching.
- `halt`  in  1  level; sampled in RUN; stops fetching and flushes.
- `mem_addr`  out  ADDR_W  instruction memory address.
- `mem_q`  in  DATA_W  memory read data, valid 1 cycle after `mem_addr`.
- `out_valid`  out  1  instruction available.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_instr`  out  DATA_W  instruction word.
- `out_pc`  out  32  byte address of `out_instr` (word address << 2).
- `redirect_valid`  in  1  one-cycle redirect request.
- `redirect_pc`  in  32  byte target address.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on RUN→IDLE.
- `fault`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: no issue; `mem_addr` = PC. `start` → RUN. A redirect in IDLE loads PC only.
- RUN: issue a read in a cycle when `count + inflight - pop < 2`, where `count` is FIFO occupancy (0..2), `inflight` is 1 if a read was issued last cycle, and `pop` is `out_valid && out_ready`. An issue presents PC on `mem_addr` and then increments PC by 1 word.
- Response: the cycle after an issue, `mem_q` is pushed into a 2-entry FIFO with its PC. It is dropped if a redirect or halt occurred in the issue cycle or the response cycle. Drop detection uses an epoch bit stored with the inflight flag.
- Output: the FIFO head drives `out_valid`, `out_instr`, and `out_pc`. These hold stable while `out_valid && !out_ready`.
- Redirect in RUN: has priority over push, pop, and issue in the same cycle.
  - FIFO is cleared and the epoch toggles.
  - PC ← `redirect_pc[ADDR_W+1:2]`.
  - No issue occurs in the redirect cycle. Issue resumes the next cycle.
  - A handshake in the redirect cycle still completes for the consumer.
- Halt in RUN: same flush as a redirect. State → IDLE, `done` pulses for 1 cycle, and PC keeps the next sequential value. Redirect and halt in the same cycle: both apply, so PC takes the target.
- PC wraps from 2^ADDR_W−1 to 0 with no flag.
- Reset mid-operation: all state is cleared immediately.

## Timing
- Reset values:
  - `out_valid`, `busy`, `done`, and `fault` = 0.
  - `out_instr` = 0 and `out_pc` = 0.
  - `mem_addr` = `RESET_PC`, PC = `RESET_PC`, FIFO empty, inflight 0, epoch 0.
- The edge that samples `start` enters RUN; the first issue is in the following cycle (C1).
- `mem_q` is captured at the end of C2, and `out_valid` rises in C3. Latency from start-sample to first `out_valid` is 3 cycles.
- With `out_ready` held high, the block sustains 1 instruction per cycle.
- After a redirect, the first target instruction appears with `out_valid` 3 cycles after the redirect cycle.

## Configuration
- `INSTR_FETCH_MISALIGN_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fault` (sticky until reset), flushes, and enters IDLE without pulsing `done`. PC is not updated.
  - `start` is ignored while `fault` = 1.
- Undefined: `redirect_pc[1:0]` is ignored and `fault` is tied to 0.

## Structure
- Package `rv_fetch_pkg` holds:
  - the state encoding (IDLE/RUN);
  - default `ADDR_W`/`DATA_W`;
  - the byte↔word PC conversion constants (shift of 2).
- Sub-module `fetch_fifo`: a 2-entry FIFO of `{DATA_W instr, 32 pc}` with push/pop/clear and `count` output. Clear has priority.
- The top level contains the FSM, PC, inflight/epoch logic, and the credit check.

## Test plan
- Reset, `start` pulse, memory words 0..3 = 0x11,0x22,0x33,0x44, `out_ready`=1 → `out_valid` first high 3 cycles after start-sample, then (0x11,pc 0x0),(0x22,0x4),(0x33,0x8),(0x44,0xC) on consecutive cycles.
- `out_ready`=0 for 5 cycles while running → FIFO fills to 2, `mem_addr` stops advancing, head stays (0x11,0x0); on release, no word is lost or duplicated.
- Redirect to 0x20 while 2 entries are buffered and 1 is inflight → `out_valid` low the next cycle, and the next accepted pair is (mem[8], 0x20) 3 cycles later; stale words never appear.
- PC at word 255 (`ADDR_W`=8), running → out_pc sequence 0x3FC then 0x000.
- `halt` in RUN → `done` 1-cycle pulse, `busy`=0, `out_valid`=0 next cycle; `start` again resumes at the next sequential PC.
- With `INSTR_FETCH_MISALIGN_EN`: redirect to 0x22 → `fault`=1, state IDLE, no `done`; `start` ignored until `rst` low.
